// File: rtl/risc_pkg.sv
// risc_pkg
// Shared definitions for the 8-bit RISC core: default datapath width,
// the opcode encoding (also used by the instruction-cycle controller),
// and the one-bit ALU result-holding state.
package risc_pkg;

    localparam int RISC_DW = 8;

    typedef enum logic [2:0] {
        HLT  = 3'b000,
        SKZ  = 3'b001,
        ADD  = 3'b010,
        ANDD = 3'b011,
        XORR = 3'b100,
        LDA  = 3'b101,
        STO  = 3'b110,
        JMP  = 3'b111
    } opcode_e;

    // Whether alu_q currently holds a result that no load_acc has consumed yet.
    typedef enum logic {
        ALU_EMPTY = 1'b0,
        ALU_FULL  = 1'b1
    } alu_state_e;

endpackage

// File: rtl/risc_alu.sv
// risc_alu
// Purely combinational ALU of the execution unit.
// Ports:
//   op   in  3   opcode selecting the operation
//   a    in  DW  accumulator operand
//   b    in  DW  data-bus operand
//   y    out DW  result (wraps modulo 2^DW)
//   cout out 1   carry-out, only meaningful for ADD (0 otherwise)
module risc_alu
    import risc_pkg::*;
#(
    parameter int DW = RISC_DW
) (
    input  logic [2:0]    op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] y,
    output logic          cout
);

    logic [DW:0] sum;

    always_comb begin
        sum  = {1'b0, a} + {1'b0, b};
        y    = a;
        cout = 1'b0;
        case (opcode_e'(op))
            ADD:     {cout, y} = sum;
            ANDD:    y = a & b;
            XORR:    y = a ^ b;
            LDA:     y = b;
            // HLT, SKZ, STO, JMP pass the accumulator through unchanged.
            default: y = a;
        endcase
    end

endmodule

// File: rtl/risc_exec_unit.sv
// risc_exec_unit
// Execution datapath of the 8-bit RISC core: accumulator, registered ALU
// result, and the write-data driver for STO.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   opcode       current opcode, sampled only when alu_ena is high
//   alu_ena      operand on data_in valid; ALU result is captured into alu_q
//   data_in      data bus read value
//   load_acc     accumulator takes the held ALU result
//   datactl_ena  drive the accumulator onto the bus
//   data_out     write data, frozen for the whole datactl_ena window
//   data_oe      bus output enable
//   acc          accumulator
//   zero         registered "accumulator is zero" flag
//   carry        carry from the last accumulated ADD
//   seq_err      sticky: load_acc seen while no ALU result was held
//
// Strobe semantics: alu_ena and load_acc are single-cycle strobes acted on
// at the rising edge where they are high; there is no back-pressure. The
// producer (alu_ena) fills a one-deep result slot and the consumer
// (load_acc) empties it; a load from an empty slot is recorded in seq_err
// and otherwise ignored. Both in one cycle: the load takes the old result
// and the new one refills the slot.
module risc_exec_unit
    import risc_pkg::*;
#(
    parameter int DW = RISC_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    opcode,
    input  logic          alu_ena,
    input  logic [DW-1:0] data_in,
    input  logic          load_acc,
    input  logic          datactl_ena,
    output logic [DW-1:0] data_out,
    output logic          data_oe,
    output logic [DW-1:0] acc,
    output logic          zero,
    output logic          carry,
    output logic          seq_err
);

    logic [2:0]    op_q,       op_d;
    logic [DW-1:0] alu_q,      alu_d;
    logic          c_q,        c_d;
    alu_state_e    alu_state_q, alu_state_d;
    logic [DW-1:0] acc_q,      acc_d;
    logic          zero_q,     zero_d;
    logic          carry_q,    carry_d;
    logic          seq_err_q,  seq_err_d;
    logic [DW-1:0] data_out_q, data_out_d;
    logic          data_oe_q,  data_oe_d;

    logic [DW-1:0] alu_y;
    logic          alu_cout;

    // The ALU always works on the accumulator as it stands before this edge,
    // so a simultaneous load does not feed into the newly captured result.
    risc_alu #(.DW(DW)) u_alu (
        .op   (opcode),
        .a    (acc_q),
        .b    (data_in),
        .y    (alu_y),
        .cout (alu_cout)
    );

    always_comb begin
        op_d        = op_q;
        alu_d       = alu_q;
        c_d         = c_q;
        alu_state_d = alu_state_q;
        acc_d       = acc_q;
        zero_d      = zero_q;
        carry_d     = carry_q;
        seq_err_d   = seq_err_q;
        data_out_d  = data_out_q;
        data_oe_d   = data_oe_q;

        // Accumulator load consumes the result captured on an earlier edge.
        if (load_acc) begin
            if (alu_state_q == ALU_FULL) begin
                acc_d       = alu_q;
                zero_d      = (alu_q == '0);
                alu_state_d = ALU_EMPTY;
                if (opcode_e'(op_q) == ADD) begin
                    carry_d = c_q;
                end
            end else begin
                seq_err_d = 1'b1;
            end
        end

        // Capture after the load so a same-cycle pair leaves the slot FULL.
        if (alu_ena) begin
            op_d        = opcode;
            alu_d       = alu_y;
            c_d         = alu_cout;
            alu_state_d = ALU_FULL;
        end

        // Bus data is latched once at the start of a STO window and frozen.
        if (datactl_ena) begin
            if (!data_oe_q) begin
                data_out_d = acc_q;
                data_oe_d  = 1'b1;
            end
        end else begin
            data_oe_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q        <= 3'b000;
            alu_q       <= '0;
            c_q         <= 1'b0;
            alu_state_q <= ALU_EMPTY;
            acc_q       <= '0;
            zero_q      <= 1'b1;
            carry_q     <= 1'b0;
            seq_err_q   <= 1'b0;
            data_out_q  <= '0;
            data_oe_q   <= 1'b0;
        end else begin
            op_q        <= op_d;
            alu_q       <= alu_d;
            c_q         <= c_d;
            alu_state_q <= alu_state_d;
            acc_q       <= acc_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
            seq_err_q   <= seq_err_d;
            data_out_q  <= data_out_d;
            data_oe_q   <= data_oe_d;
        end
    end

    assign acc      = acc_q;
    assign zero     = zero_q;
    assign carry    = carry_q;
    assign seq_err  = seq_err_q;
    assign data_out = data_out_q;
    assign data_oe  = data_oe_q;

endmodule

// File: tb/tb_risc_exec_unit.sv
// tb_risc_exec_unit
// Self-checking bench for risc_exec_unit: a table of single instructions,
// hand-written multi-cycle sequences, then random traffic compared against
// a queue-based reference model.
module tb_risc_exec_unit;
    import risc_pkg::*;

    localparam int DW = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [2:0]    opcode;
    logic          alu_ena;
    logic [DW-1:0] data_in;
    logic          load_acc;
    logic          datactl_ena;
    logic [DW-1:0] data_out;
    logic          data_oe;
    logic [DW-1:0] acc;
    logic          zero;
    logic          carry;
    logic          seq_err;

    risc_exec_unit #(.DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .alu_ena     (alu_ena),
        .data_in     (data_in),
        .load_acc    (load_acc),
        .datactl_ena (datactl_ena),
        .data_out    (data_out),
        .data_oe     (data_oe),
        .acc         (acc),
        .zero        (zero),
        .carry       (carry),
        .seq_err     (seq_err)
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [7:0] e_acc, input logic e_zero,
                               input logic e_carry, input logic e_err);
        check({tag, ".acc"},     32'(acc),     32'(e_acc));
        check({tag, ".zero"},    32'(zero),    32'(e_zero));
        check({tag, ".carry"},   32'(carry),   32'(e_carry));
        check({tag, ".seq_err"}, 32'(seq_err), 32'(e_err));
    endtask

    task automatic check_bus(input string tag, input logic [7:0] e_dout, input logic e_oe);
        check({tag, ".data_out"}, 32'(data_out), 32'(e_dout));
        check({tag, ".data_oe"},  32'(data_oe),  32'(e_oe));
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst         = 1'b0;
        alu_ena     = 1'b0;
        load_acc    = 1'b0;
        datactl_ena = 1'b0;
        opcode      = HLT;
        data_in     = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // alu_ena with the operand, then load_acc with a different opcode and bus
    // value on the wires to show they are not re-sampled at load time.
    task automatic do_op(input logic [2:0] op, input logic [7:0] d);
        opcode  = op;
        data_in = d;
        alu_ena = 1'b1;
        tick();
        alu_ena  = 1'b0;
        load_acc = 1'b1;
        opcode   = ADD;
        data_in  = 8'($urandom_range(0, 255));
        tick();
        load_acc = 1'b0;
    endtask

    // ---------------- reference model ----------------
    // exp_q holds the pending ALU result: {is_add, carry, value}.
    logic [DW+1:0] exp_q[$];
    logic [DW-1:0] m_acc, m_dout;
    logic          m_zero, m_carry, m_err, m_oe;

    task automatic model_reset();
        m_acc   = '0;
        m_zero  = 1'b1;
        m_carry = 1'b0;
        m_err   = 1'b0;
        m_dout  = '0;
        m_oe    = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_edge();
        logic [DW-1:0] old_acc;
        logic [DW:0]   sum;
        logic [DW+1:0] res;
        logic [DW+1:0] r;
        if (rst) begin
            model_reset();
            return;
        end
        old_acc = m_acc;
        sum = {1'b0, old_acc} + {1'b0, data_in};
        case (opcode)
            3'b010:  res = {1'b1, sum[DW], sum[DW-1:0]};
            3'b011:  res = {2'b00, old_acc & data_in};
            3'b100:  res = {2'b00, old_acc ^ data_in};
            3'b101:  res = {2'b00, data_in};
            default: res = {2'b00, old_acc};
        endcase
        if (load_acc) begin
            if (exp_q.size() > 0) begin
                r = exp_q.pop_front();
                m_acc  = r[DW-1:0];
                m_zero = (m_acc == 0);
                if (r[DW+1]) m_carry = r[DW];
            end else begin
                m_err = 1'b1;
            end
        end
        if (alu_ena) begin
            exp_q.delete();
            exp_q.push_back(res);
        end
        if (datactl_ena) begin
            if (!m_oe) begin
                m_dout = old_acc;
                m_oe   = 1'b1;
            end
        end else begin
            m_oe = 1'b0;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [2:0] op;
        logic [7:0] din;
        logic [7:0] e_acc;
        logic       e_zero;
        logic       e_carry;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{LDA,  8'h3C, 8'h3C, 1'b0, 1'b0};
        vecs[1] = '{ADD,  8'hD0, 8'h0C, 1'b0, 1'b1};
        vecs[2] = '{XORR, 8'h0C, 8'h00, 1'b1, 1'b1};
        vecs[3] = '{ANDD, 8'hFF, 8'h00, 1'b1, 1'b1};
        vecs[4] = '{LDA,  8'h20, 8'h20, 1'b0, 1'b1};
        vecs[5] = '{ADD,  8'h15, 8'h35, 1'b0, 1'b0};

        idle();
        do_reset();
        repeat (2) tick();
        check_state("reset", 8'h00, 1'b1, 1'b0, 1'b0);
        check_bus("reset", 8'h00, 1'b0);

        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i].op, vecs[i].din);
            check_state($sformatf("vec%0d", i), vecs[i].e_acc, vecs[i].e_zero,
                        vecs[i].e_carry, 1'b0);
        end

        // STO window of 3 cycles with an LDA landing in the middle.
        do_op(LDA, 8'h5A);
        datactl_ena = 1'b1;
        opcode      = LDA;
        data_in     = 8'h11;
        alu_ena     = 1'b1;
        tick();
        check_bus("sto1", 8'h5A, 1'b1);
        alu_ena  = 1'b0;
        load_acc = 1'b1;
        tick();
        load_acc = 1'b0;
        check_bus("sto2", 8'h5A, 1'b1);
        check("sto2.acc", 32'(acc), 32'h11);
        tick();
        check_bus("sto3", 8'h5A, 1'b1);
        datactl_ena = 1'b0;
        tick();
        check_bus("sto_end", 8'h5A, 1'b0);

        // Load with nothing pending, then sticky error through a valid op.
        load_acc = 1'b1;
        tick();
        load_acc = 1'b0;
        check_state("seq_err", 8'h11, 1'b0, 1'b0, 1'b1);
        do_op(LDA, 8'h77);
        check_state("seq_err_sticky", 8'h77, 1'b0, 1'b0, 1'b1);
        do_reset();
        check_state("seq_err_rst", 8'h00, 1'b1, 1'b0, 1'b0);

        // Overlapped capture and load.
        opcode  = LDA;
        data_in = 8'h22;
        alu_ena = 1'b1;
        tick();
        data_in  = 8'h33;
        load_acc = 1'b1;
        tick();
        alu_ena = 1'b0;
        check_state("overlap1", 8'h22, 1'b0, 1'b0, 1'b0);
        tick();
        load_acc = 1'b0;
        check_state("overlap2", 8'h33, 1'b0, 1'b0, 1'b0);

        // Reset beats a same-cycle capture: a following load finds nothing.
        opcode  = ADD;
        data_in = 8'h01;
        alu_ena = 1'b1;
        rst     = 1'b1;
        tick();
        rst     = 1'b0;
        alu_ena = 1'b0;
        check_state("rst_mid", 8'h00, 1'b1, 1'b0, 1'b0);
        load_acc = 1'b1;
        tick();
        load_acc = 1'b0;
        check_state("rst_mid_load", 8'h00, 1'b1, 1'b0, 1'b1);
        do_reset();

        // Reset during a STO window drops the output enable at that edge.
        do_op(LDA, 8'h66);
        datactl_ena = 1'b1;
        tick();
        check_bus("sto_rst_a", 8'h66, 1'b1);
        rst = 1'b1;
        tick();
        rst         = 1'b0;
        datactl_ena = 1'b0;
        check_bus("sto_rst_b", 8'h00, 1'b0);

        // ---------------- random phase ----------------
        idle();
        do_reset();
        model_reset();
        for (int c = 0; c < 600; c++) begin
            rst      = ($urandom_range(0, 79) == 0);
            alu_ena  = ($urandom_range(0, 2) == 0);
            load_acc = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) datactl_ena = ~datactl_ena;
            opcode  = 3'($urandom_range(0, 7));
            data_in = 8'($urandom_range(0, 255));
            tick();
            model_edge();
            check("rnd.acc",      32'(acc),      32'(m_acc));
            check("rnd.zero",     32'(zero),     32'(m_zero));
            check("rnd.carry",    32'(carry),    32'(m_carry));
            check("rnd.seq_err",  32'(seq_err),  32'(m_err));
            check("rnd.data_out", 32'(data_out), 32'(m_dout));
            check("rnd.data_oe",  32'(data_oe),  32'(m_oe));
        end

        // ---------------- report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
